// File: rtl/ni_resp_flit_packer.sv
// Response packet serialiser: walks the header through the external shifter,
// appends FIFO payload words, types each flit and drives a registered valid/ready stage.
//
// state   | meaning
// IDLE    | waiting for resp_valid; header flit 0 goes out on acceptance
// HEADER  | emitting header flits 1..HEADER_FLITS-1 via flit_counter
// PAYLOAD | emitting burst_len payload words popped from the FIFO
module ni_resp_flit_packer #(
  parameter int FLIT_WIDTH   = 32,
  parameter int BASE_WIDTH   = FLIT_WIDTH - 2,
  parameter int HEADER_FLITS = 2,
  parameter int CNTW         = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  resp_valid,
  input  logic [CNTW-1:0]       burst_len,
  output logic                  resp_done,
  output logic [CNTW-1:0]       flit_counter,
  output logic                  is_payload,
  input  logic [BASE_WIDTH-1:0] header_chunk,
  input  logic [BASE_WIDTH-1:0] payload_data,
  input  logic                  payload_valid,
  output logic                  payload_pop,
  output logic [FLIT_WIDTH-1:0] flit_out,
  output logic                  flit_valid,
  input  logic                  flit_ready
);

  localparam logic [1:0] T_HEAD   = 2'b10;
  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_TAIL   = 2'b01;
  localparam logic [1:0] T_SINGLE = 2'b11;
  localparam logic [CNTW-1:0] LAST_HDR = CNTW'(HEADER_FLITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD} state_t;

  state_t                state, state_nxt;
  logic [CNTW-1:0]       burst_cnt, burst_cnt_nxt, counter_nxt;
  logic                  is_payload_nxt;
  logic                  free, load, last;
  logic [1:0]            ftype;
  logic [BASE_WIDTH-1:0] data;

  assign free = !flit_valid || flit_ready;

  always_comb begin
    state_nxt      = state;
    burst_cnt_nxt  = burst_cnt;
    counter_nxt    = flit_counter;
    is_payload_nxt = is_payload;
    load           = 1'b0;
    last           = 1'b0;
    ftype          = T_BODY;
    data           = header_chunk;
    payload_pop    = 1'b0;
    case (state)
      S_IDLE: begin
        if (resp_valid && free) begin
          load          = 1'b1;
          burst_cnt_nxt = burst_len;
          ftype         = T_HEAD;
          if (HEADER_FLITS == 1) begin
            if (burst_len == '0) begin
              last  = 1'b1;
              ftype = T_SINGLE;
            end else begin
              state_nxt      = S_PAYLOAD;
              is_payload_nxt = 1'b1;
            end
          end else begin
            state_nxt   = S_HEADER;
            counter_nxt = CNTW'(1);
          end
        end
      end
      S_HEADER: begin
        if (free) begin
          load        = 1'b1;
          counter_nxt = flit_counter + CNTW'(1);
          if (flit_counter == LAST_HDR) begin
            if (burst_cnt == '0) begin
              last        = 1'b1;
              ftype       = T_TAIL;
              state_nxt   = S_IDLE;
              counter_nxt = '0;
            end else begin
              state_nxt      = S_PAYLOAD;
              is_payload_nxt = 1'b1;
            end
          end
        end
      end
      S_PAYLOAD: begin
        data = payload_data;
        if (free && payload_valid) begin
          load          = 1'b1;
          payload_pop   = 1'b1;
          burst_cnt_nxt = burst_cnt - CNTW'(1);
          if (burst_cnt == CNTW'(1)) begin
            last           = 1'b1;
            ftype          = T_TAIL;
            state_nxt      = S_IDLE;
            counter_nxt    = '0;
            is_payload_nxt = 1'b0;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Tail detection is combinational so done lines up with the tail load edge.
  assign resp_done = last;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      burst_cnt    <= '0;
      flit_counter <= '0;
      is_payload   <= 1'b0;
      flit_out     <= '0;
      flit_valid   <= 1'b0;
    end else begin
      state        <= state_nxt;
      burst_cnt    <= burst_cnt_nxt;
      flit_counter <= counter_nxt;
      is_payload   <= is_payload_nxt;
      if (load) begin
        flit_out   <= {ftype, data};
        flit_valid <= 1'b1;
      end else if (flit_ready) begin
        flit_valid <= 1'b0;
      end
    end
  end

endmodule
